// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the half-word SRAM word controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  localparam int SRAM_DW    = 16;
  localparam int SRAM_BYTES = 2;

  // Ceiling log2; clog2(1) is 0 so single-beat configurations get no beat field.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// Beat (b) and wait (w) counters for one transfer; also exposes next-cycle values
// so the top can register SRAM pins one cycle ahead.
module sram_beat_timer
  import sram_ctrl_pkg::*;
#(
  parameter int  BEATS       = 2,
  parameter int  WAIT_CYCLES = 1,
  localparam int BB          = clog2(BEATS),
  localparam int BW          = (BB < 1) ? 1 : BB,
  localparam int WW          = clog2(WAIT_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          run,
  output logic [BW-1:0] b,
  output logic [BW-1:0] b_nxt,
  output logic [WW-1:0] w_nxt,
  output logic          beat_last_cycle,
  output logic          xfer_last
);

  logic [WW-1:0] w;

  assign beat_last_cycle = (w == WW'(WAIT_CYCLES));
  assign xfer_last       = beat_last_cycle && (b == BW'(BEATS - 1));

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_nxt = w;
    b_nxt = b;
    if (clear) begin
      w_nxt = '0;
      b_nxt = '0;
    end else if (run) begin
      if (beat_last_cycle) begin
        w_nxt = '0;
        b_nxt = (b == BW'(BEATS - 1)) ? '0 : b + 1'b1;
      end else begin
        w_nxt = w + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w <= '0;
      b <= '0;
    end else begin
      w <= w_nxt;
      b <= b_nxt;
    end
  end

endmodule

// File: rtl/sram_word_controller.sv
// Moves one CPU word per request to/from a 16-bit async SRAM as little-endian half-word beats.
// SRAM pins are registered from next-cycle values, so strobes never glitch.
module sram_word_controller
  import sram_ctrl_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wrEn,
  input  logic                rdEn,
  input  logic [31:0]         address,
  input  logic [WORD_W-1:0]   writeData,
  input  logic [WORD_W/8-1:0] byteEn,
  output logic [WORD_W-1:0]   readData,
  output logic                ready,
  inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
  output logic [SRAM_AW-1:0]  SRAM_ADDR,
  output logic                SRAM_WE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N
);

  localparam int BEATS = WORD_W / SRAM_DW;
  localparam int BB    = clog2(BEATS);
  localparam int BW    = (BB < 1) ? 1 : BB;
  localparam int WW    = clog2(WAIT_CYCLES + 1);
  localparam int BE_W  = WORD_W / 8;
  localparam int HW    = SRAM_AW - BB;

  state_t state, state_nxt;
  logic take;
  logic [HW-1:0] base_q, base_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [BE_W-1:0] be_q, be_d;
  logic wr_q, wr_d;
  logic [BW-1:0] b, b_nxt;
  logic [WW-1:0] w_nxt;
  logic beat_last_cycle, xfer_last;
  logic capture;
  logic [WORD_W-1:0] shadow_q, shadow_d;
  logic [SRAM_AW-1:0] beat_addr, addr_pin_d;
  logic [SRAM_BYTES-1:0] be_beat;
  logic [SRAM_DW-1:0] dq_out_d, dq_out_q;
  logic dq_oe_d, dq_oe_q;
  logic we_n_d, oe_n_d, ce_n_d, ub_n_d, lb_n_d;
  logic unused_addr;

  assign take  = (state == ST_IDLE) && (wrEn || rdEn);
  assign ready = ((state == ST_IDLE) && !(wrEn || rdEn)) || (state == ST_DONE);

  // Request fields pass straight through in the accept cycle so beat 0 pins can be registered then.
  assign base_d = take ? address[SRAM_AW:BB+1] : base_q;
  assign data_d = take ? writeData : data_q;
  assign be_d   = take ? byteEn : be_q;
  assign wr_d   = take ? wrEn : wr_q;
  assign unused_addr = ^{address[31:SRAM_AW+1], address[BB:0]};

  if (BB == 0) begin : g_single_beat
    assign beat_addr = base_d;
  end else begin : g_multi_beat
    assign beat_addr = {base_d, b_nxt};
  end

  sram_beat_timer #(
    .BEATS       (BEATS),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_timer (
    .clk             (clk),
    .rst             (rst),
    .clear           (state == ST_IDLE),
    .run             (state == ST_ACCESS),
    .b               (b),
    .b_nxt           (b_nxt),
    .w_nxt           (w_nxt),
    .beat_last_cycle (beat_last_cycle),
    .xfer_last       (xfer_last)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (wrEn || rdEn) state_nxt = ST_ACCESS;
      ST_ACCESS: if (xfer_last) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    be_beat    = SRAM_BYTES'(be_d >> (int'(b_nxt) * SRAM_BYTES));
    dq_out_d   = SRAM_DW'(data_d >> (int'(b_nxt) * SRAM_DW));
    addr_pin_d = '0;
    dq_oe_d    = 1'b0;
    we_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    ce_n_d     = 1'b1;
    ub_n_d     = 1'b1;
    lb_n_d     = 1'b1;
    if (state_nxt == ST_ACCESS) begin
      addr_pin_d = beat_addr;
      ce_n_d     = 1'b0;
      if (wr_d) begin
        dq_oe_d = 1'b1;
        lb_n_d  = !be_beat[0];
        ub_n_d  = !be_beat[1];
        // WE_N rises on the beat's final cycle while address and data are still held.
        we_n_d  = !((w_nxt < WW'(WAIT_CYCLES)) && (|be_beat));
      end else begin
        oe_n_d = 1'b0;
        ub_n_d = 1'b0;
        lb_n_d = 1'b0;
      end
    end
  end

  assign capture = (state == ST_ACCESS) && !wr_q && beat_last_cycle;

  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < BEATS; i++) begin
      if (capture && (int'(b) == i)) shadow_d[i*SRAM_DW +: SRAM_DW] = SRAM_DQ;
    end
  end

  // NOTE: request latches and the read shadow are plain registers, reset so nothing powers up X.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      base_q   <= '0;
      data_q   <= '0;
      be_q     <= '0;
      wr_q     <= 1'b0;
      shadow_q <= '0;
      readData <= '0;
    end else begin
      state    <= state_nxt;
      base_q   <= base_d;
      data_q   <= data_d;
      be_q     <= be_d;
      wr_q     <= wr_d;
      shadow_q <= shadow_d;
      if (capture && xfer_last) readData <= shadow_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_CE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
      dq_oe_q   <= 1'b0;
      dq_out_q  <= '0;
    end else begin
      SRAM_ADDR <= addr_pin_d;
      SRAM_WE_N <= we_n_d;
      SRAM_OE_N <= oe_n_d;
      SRAM_CE_N <= ce_n_d;
      SRAM_UB_N <= ub_n_d;
      SRAM_LB_N <= lb_n_d;
      dq_oe_q   <= dq_oe_d;
      dq_out_q  <= dq_out_d;
    end
  end

  assign SRAM_DQ = dq_oe_q ? dq_out_q : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_sram_word_controller.sv
// Directed bench for sram_word_controller: a 32-bit/1-wait instance and a 64-bit/3-wait
// instance, each attached to a small behavioural async SRAM.
module tb_sram_word_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        wr32, rd32, ready32;
  logic [31:0] addr32, wdata32, rdata32;
  logic [3:0]  be32;
  wire  [15:0] dq32;
  logic [17:0] sa32;
  logic        we32, oe32, ce32, ub32, lb32;

  logic        wr64, rd64, ready64;
  logic [31:0] addr64;
  logic [63:0] wdata64, rdata64;
  logic [7:0]  be64;
  wire  [15:0] dq64;
  logic [17:0] sa64;
  logic        we64, oe64, ce64, ub64, lb64;

  sram_word_controller dut (
    .clk(clk), .rst(rst), .wrEn(wr32), .rdEn(rd32), .address(addr32),
    .writeData(wdata32), .byteEn(be32), .readData(rdata32), .ready(ready32),
    .SRAM_DQ(dq32), .SRAM_ADDR(sa32), .SRAM_WE_N(we32), .SRAM_OE_N(oe32),
    .SRAM_CE_N(ce32), .SRAM_UB_N(ub32), .SRAM_LB_N(lb32)
  );

  sram_word_controller #(.WORD_W(64), .SRAM_AW(18), .WAIT_CYCLES(3)) dut64 (
    .clk(clk), .rst(rst), .wrEn(wr64), .rdEn(rd64), .address(addr64),
    .writeData(wdata64), .byteEn(be64), .readData(rdata64), .ready(ready64),
    .SRAM_DQ(dq64), .SRAM_ADDR(sa64), .SRAM_WE_N(we64), .SRAM_OE_N(oe64),
    .SRAM_CE_N(ce64), .SRAM_UB_N(ub64), .SRAM_LB_N(lb64)
  );

  // Behavioural SRAMs: drive DQ while selected with OE low, store bytes on edges with WE low.
  logic [15:0] mem32 [0:255];
  logic [15:0] mem64 [0:255];

  assign dq32 = (!ce32 && !oe32) ? mem32[sa32[7:0]] : 16'hzzzz;
  assign dq64 = (!ce64 && !oe64) ? mem64[sa64[7:0]] : 16'hzzzz;

  logic dq32_z, dq64_z;
  assign dq32_z = (dq32 === 16'hzzzz);
  assign dq64_z = (dq64 === 16'hzzzz);

  always @(posedge clk) begin
    if (!rst) begin
      mem32[8'h10] <= 16'h1234;
      mem32[8'h11] <= 16'h5678;
      mem64[8'h80] <= 16'hA0B1;
      mem64[8'h81] <= 16'hC2D3;
      mem64[8'h82] <= 16'hE4F5;
      mem64[8'h83] <= 16'h0617;
    end else begin
      if (!ce32 && !we32) begin
        if (!lb32) mem32[sa32[7:0]][7:0]  <= dq32[7:0];
        if (!ub32) mem32[sa32[7:0]][15:8] <= dq32[15:8];
      end
      if (!ce64 && !we64) begin
        if (!lb64) mem64[sa64[7:0]][7:0]  <= dq64[7:0];
        if (!ub64) mem64[sa64[7:0]][15:8] <= dq64[15:8];
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Per-cycle pin record of the last transfer; index 0 is the request cycle.
  logic [17:0] r_addr  [0:31];
  logic [15:0] r_dq    [0:31];
  logic [63:0] r_rdata [0:31];
  logic        r_z [0:31], r_we [0:31], r_oe [0:31], r_ce [0:31];
  logic        r_ub [0:31], r_lb [0:31], r_rdy [0:31];
  int          lat;

  // Called just after a rising edge; returns the cycle index at which ready came back (-1 on timeout).
  task automatic xfer(input bit sel64, input logic wr, input logic rd, input logic [31:0] a,
                      input logic [63:0] d, input logic [7:0] be, output int lat_o);
    if (sel64) begin
      wr64 = wr; rd64 = rd; addr64 = a; wdata64 = d; be64 = be;
    end else begin
      wr32 = wr; rd32 = rd; addr32 = a; wdata32 = d[31:0]; be32 = be[3:0];
    end
    lat_o = -1;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (sel64) begin
        r_addr[c] = sa64; r_dq[c] = dq64; r_z[c] = dq64_z; r_we[c] = we64; r_oe[c] = oe64;
        r_ce[c] = ce64; r_ub[c] = ub64; r_lb[c] = lb64; r_rdata[c] = rdata64; r_rdy[c] = ready64;
      end else begin
        r_addr[c] = sa32; r_dq[c] = dq32; r_z[c] = dq32_z; r_we[c] = we32; r_oe[c] = oe32;
        r_ce[c] = ce32; r_ub[c] = ub32; r_lb[c] = lb32; r_rdata[c] = {32'h0, rdata32}; r_rdy[c] = ready32;
      end
      if (c > 0 && r_rdy[c]) begin
        lat_o = c;
        break;
      end
    end
    @(posedge clk);
    #1;
    wr32 = 1'b0; rd32 = 1'b0; wr64 = 1'b0; rd64 = 1'b0;
  endtask

  logic [11:0] ce_seq, rdy_seq;

  initial begin
    rst = 1'b0;
    wr32 = 0; rd32 = 0; addr32 = 0; wdata32 = 0; be32 = 0;
    wr64 = 0; rd64 = 0; addr64 = 0; wdata64 = 0; be64 = 0;

    #12;
    check("rst_strobes", {we32, oe32, ce32, ub32, lb32}, 5'b11111);
    check("rst_addr", sa32, 18'h0);
    check("rst_dq_z", dq32_z, 1'b1);
    check("rst_rdata", rdata32, 32'h0);
    check("rst_ready", ready32, 1'b1);
    check("rst_strobes64", {we64, oe64, ce64, ub64, lb64}, 5'b11111);
    check("rst_rdata64", rdata64, 64'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Full-word write at 0x10.
    xfer(1'b0, 1'b1, 1'b0, 32'h10, 64'hDEADBEEF, 8'hF, lat);
    check("wr_ready_req_cycle", r_rdy[0], 1'b0);
    check("wr_latency", lat, 5);
    check("wr_addr_beats", {r_addr[1], r_addr[2], r_addr[3], r_addr[4]}, {18'h8, 18'h8, 18'h9, 18'h9});
    check("wr_dq_beats", {r_dq[1], r_dq[2], r_dq[3], r_dq[4]}, 64'hBEEF_BEEF_DEAD_DEAD);
    check("wr_we_seq", {r_we[1], r_we[2], r_we[3], r_we[4]}, 4'b0101);
    check("wr_ce_seq", {r_ce[1], r_ce[2], r_ce[3], r_ce[4], r_ce[5]}, 5'b00001);
    check("wr_oe_high", {r_oe[1], r_oe[3]}, 2'b11);
    check("wr_byte_strobes", {r_ub[1], r_lb[1], r_ub[3], r_lb[3]}, 4'b0000);
    check("wr_dq_released_done", r_z[5], 1'b1);
    check("wr_rdata_unchanged", r_rdata[5], 64'h0);
    check("wr_mem_lo", mem32[8'h08], 16'hBEEF);
    check("wr_mem_hi", mem32[8'h09], 16'hDEAD);

    // Read back the same word.
    xfer(1'b0, 1'b0, 1'b1, 32'h10, 64'h0, 8'h0, lat);
    check("rd_latency", lat, 5);
    check("rd_oe_seq", {r_oe[1], r_oe[2], r_oe[3], r_oe[4], r_oe[5]}, 5'b00001);
    check("rd_we_high", {r_we[1], r_we[2], r_we[3], r_we[4]}, 4'b1111);
    check("rd_strobes_low", {r_ub[1], r_lb[1], r_ub[4], r_lb[4]}, 4'b0000);
    check("rd_no_partial", r_rdata[4], 64'h0);
    check("rd_data_done", r_rdata[5], 64'hDEADBEEF);

    // Single byte: lane 2 only.
    xfer(1'b0, 1'b1, 1'b0, 32'h20, 64'h00AA0000, 8'b0100, lat);
    check("be_latency", lat, 5);
    check("be_beat0_strobes", {r_ub[1], r_lb[1]}, 2'b11);
    check("be_beat1_strobes", {r_ub[3], r_lb[3]}, 2'b10);
    check("be_we_seq", {r_we[1], r_we[2], r_we[3], r_we[4]}, 4'b1101);
    check("be_dq_beat1", r_dq[3], 16'h00AA);
    check("be_mem_untouched", mem32[8'h10], 16'h1234);
    check("be_mem_merged", mem32[8'h11], 16'h56AA);

    // Write and read both requested: write wins.
    xfer(1'b0, 1'b1, 1'b1, 32'h30, 64'hCAFEF00D, 8'hF, lat);
    check("both_latency", lat, 5);
    check("both_oe_high", r_oe[1], 1'b1);
    check("both_we_low", r_we[1], 1'b0);
    check("both_rdata_kept", r_rdata[5], 64'hDEADBEEF);
    check("both_mem_lo", mem32[8'h18], 16'hF00D);
    check("both_mem_hi", mem32[8'h19], 16'hCAFE);

    // rdEn held over two transfers; the address change mid-transfer only reaches the second.
    rd32 = 1'b1; addr32 = 32'h30;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      ce_seq[11-c]  = ce32;
      rdy_seq[11-c] = ready32;
      if (c == 1) addr32 = 32'h10;
      if (c == 3) check("b2b_addr_ignored", sa32, 18'h19);
      if (c == 5) check("b2b_rdata_first", rdata32, 32'hCAFEF00D);
      if (c == 7) check("b2b_addr_second", sa32, 18'h08);
      if (c == 10) check("b2b_rdata_held", rdata32, 32'hCAFEF00D);
      if (c == 11) check("b2b_rdata_second", rdata32, 32'hDEADBEEF);
    end
    @(posedge clk);
    #1 rd32 = 1'b0;
    check("b2b_ce_seq", ce_seq, 12'b1000_0110_0001);
    check("b2b_ready_seq", rdy_seq, 12'b0000_0100_0001);

    // 64-bit word, three wait cycles per beat.
    xfer(1'b1, 1'b0, 1'b1, 32'h100, 64'h0, 8'h0, lat);
    check("w64_latency", lat, 17);
    check("w64_addr_beats", {r_addr[1], r_addr[5], r_addr[9], r_addr[13]},
          {18'h80, 18'h81, 18'h82, 18'h83});
    check("w64_addr_beat_end", {r_addr[4], r_addr[16]}, {18'h80, 18'h83});
    check("w64_oe_span", {r_oe[1], r_oe[16], r_oe[17]}, 3'b001);
    check("w64_we_high", {r_we[1], r_we[8], r_we[16]}, 3'b111);
    check("w64_no_partial", r_rdata[16], 64'h0);
    check("w64_rdata", r_rdata[17], 64'h0617_E4F5_C2D3_A0B1);
    check("w64_ce_done", r_ce[17], 1'b1);

    // Reset asserted during beat 1 of a write.
    wr32 = 1'b1; addr32 = 32'h40; wdata32 = 32'h11112222; be32 = 4'hF;
    for (int c = 0; c < 4; c++) @(negedge clk);
    check("rst_mid_pre_we", we32, 1'b0);
    check("rst_mid_pre_dq", dq32, 16'h1111);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_we", we32, 1'b1);
    check("rst_mid_ce", ce32, 1'b1);
    check("rst_mid_dq_z", dq32_z, 1'b1);
    check("rst_mid_addr", sa32, 18'h0);
    check("rst_mid_rdata", rdata32, 32'h0);
    wr32 = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_rel_ready", ready32, 1'b1);
    check("rst_rel_ce", ce32, 1'b1);
    repeat (3) @(negedge clk);
    check("rst_rel_quiet", {ce32, we32, ready32}, 3'b111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
